// File: rtl/counter_run_ctrl_if.sv
// Control strobes and status of the counter run controller.
// master drives the strobes and Limit; slave owns the count and status.
interface counter_run_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             Start;
  logic             Stop;
  logic             Clear;
  logic             Mode;
  logic [WIDTH-1:0] Limit;
  logic [WIDTH-1:0] Q;
  logic             CntEn;
  logic             Busy;
  logic             Done;
  logic [1:0]       State;

  modport master (
    output Start, Stop, Clear, Mode, Limit,
    input  Q, CntEn, Busy, Done, State
  );

  modport slave (
    input  Start, Stop, Clear, Mode, Limit,
    output Q, CntEn, Busy, Done, State
  );
endinterface

// File: rtl/counter_run_ctrl.sv
// Run controller for an enabled up-counter: start/pause/resume/clear, prescaled steps.
// Q advances DIV cycles after each step boundary; Done pulses the cycle after terminal count.
module counter_run_ctrl #(
  parameter int WIDTH = 4,
  parameter int DIV   = 4
) (
  input  logic               Clk,
  input  logic               RSTB,
  counter_run_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam logic [7:0] PRE_LAST = 8'(DIV - 1);

  state_t           state;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] lim;
  logic [7:0]       pre;
  logic             done;

  logic             step;
  logic [WIDTH:0]   q_inc;
  logic             at_term;

  assign step    = (state == RUN) && (pre == PRE_LAST) && !bus.Stop && !bus.Clear;
  assign q_inc   = {1'b0, q} + {{WIDTH{1'b0}}, 1'b1};
  // Compared one bit wider so a limit of all-ones never wraps Q through zero.
  assign at_term = (q_inc == {1'b0, lim});

  always_ff @(posedge Clk) begin
    if (!RSTB) begin
      state <= IDLE;
      q     <= '0;
      lim   <= '0;
      pre   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.Clear) begin
        state <= IDLE;
        q     <= '0;
        pre   <= '0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (bus.Start) begin
              lim <= bus.Limit;
              q   <= '0;
              pre <= '0;
              if (bus.Limit == '0) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state <= RUN;
              end
            end
          end
          RUN: begin
            if (bus.Stop) begin
              state <= PAUSE;
            end else if (step) begin
              pre <= '0;
              if (at_term) begin
                done <= 1'b1;
                if (bus.Mode) begin
                  q <= '0;
                end else begin
                  q     <= lim;
                  state <= DONE;
                end
              end else begin
                q <= q_inc[WIDTH-1:0];
              end
            end else begin
              pre <= pre + 8'd1;
            end
          end
          PAUSE: begin
            // Prescaler is left untouched so the partial step resumes where it stopped.
            if (!bus.Stop && bus.Start) begin
              state <= RUN;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.Q     = q;
  assign bus.CntEn = step;
  assign bus.Busy  = (state == RUN) || (state == PAUSE);
  assign bus.Done  = done;
  assign bus.State = state;

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Randomized bench for counter_run_ctrl against a cycle-count reference model.
module tb_counter_run_ctrl;

  localparam int WIDTH = 4;
  localparam int DIV   = 4;
  localparam int NCYC  = 5000;

  logic Clk;
  logic RSTB;

  counter_run_ctrl_if #(.WIDTH(WIDTH)) bus ();

  counter_run_ctrl #(.WIDTH(WIDTH), .DIV(DIV)) dut (
    .Clk  (Clk),
    .RSTB (RSTB),
    .bus  (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks;
  int failures;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Reference: states as plain ints (0 idle, 1 run, 2 pause, 3 done);
  // m_run counts unpaused RUN edges since the last start, a step lands on every DIV-th.
  int m_state;
  int m_q;
  int m_lim;
  int m_run;
  int m_done;

  function automatic int m_cnten();
    return (m_state == 1 && (m_run % DIV) == DIV - 1 && !bus.Stop && !bus.Clear) ? 1 : 0;
  endfunction

  task automatic model_edge();
    int nd;
    nd = 0;
    if (!RSTB) begin
      m_state = 0; m_q = 0; m_lim = 0; m_run = 0;
    end else if (bus.Clear) begin
      m_state = 0; m_q = 0; m_run = 0;
    end else if (m_state == 0 || m_state == 3) begin
      if (bus.Start) begin
        m_lim = int'(bus.Limit);
        m_q   = 0;
        m_run = 0;
        if (m_lim == 0) begin
          m_state = 3;
          nd = 1;
        end else begin
          m_state = 1;
        end
      end
    end else if (m_state == 1) begin
      if (bus.Stop) begin
        m_state = 2;
      end else begin
        m_run = m_run + 1;
        if (m_run % DIV == 0) begin
          if (m_q + 1 == m_lim) begin
            nd = 1;
            if (bus.Mode) m_q = 0;
            else begin
              m_q = m_lim;
              m_state = 3;
            end
          end else begin
            m_q = m_q + 1;
          end
        end
      end
    end else begin
      if (bus.Start && !bus.Stop) m_state = 1;
    end
    m_done = nd;
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".Q"},     int'(bus.Q),     m_q);
    chk({ph, ".State"}, int'(bus.State), m_state);
    chk({ph, ".Busy"},  int'(bus.Busy),  (m_state == 1 || m_state == 2) ? 1 : 0);
    chk({ph, ".Done"},  int'(bus.Done),  m_done);
    chk({ph, ".CntEn"}, int'(bus.CntEn), m_cnten());
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    m_state = 0; m_q = 0; m_lim = 0; m_run = 0; m_done = 0;

    // Start held during reset must leave the block idle.
    RSTB      = 1'b0;
    bus.Start = 1'b1;
    bus.Stop  = 1'b0;
    bus.Clear = 1'b0;
    bus.Mode  = 1'b0;
    bus.Limit = 4'd3;
    repeat (3) begin
      @(posedge Clk);
      model_edge();
    end
    @(negedge Clk);
    bus.Start = 1'b0;
    #1;
    check_all("reset");

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge Clk);
      RSTB      = ($urandom_range(0, 299) != 0);
      bus.Clear = ($urandom_range(0, 149) == 0);
      bus.Stop  = ($urandom_range(0, 24) == 0);
      bus.Start = !bus.Stop && ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 29) == 0) bus.Mode = ~bus.Mode;
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 7) == 0) bus.Limit = 4'd0;
        else bus.Limit = 4'($urandom_range(1, 15));
      end
      #1;
      // Outputs here reflect the last edge only, even if RSTB just fell.
      check_all("run");
      @(posedge Clk);
      model_edge();
    end

    @(negedge Clk);
    RSTB      = 1'b1;
    bus.Start = 1'b0;
    bus.Stop  = 1'b0;
    bus.Clear = 1'b0;
    #1;
    check_all("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
